// File: rtl/wb_burst_seq.sv
// wb_burst_seq -- four-requester Wishbone burst sequencer.
//
// Arbitrates round-robin between four Wishbone requesters, loads the
// granted requester's start address / cycle type / burst type into an
// external address generator (init_o, then one settling cycle), and then
// acknowledges one beat per cycle in which memory is ready and the granted
// requester strobes. A burst ends on a beat carrying the generator's last-beat
// flag or a classic/end-of-burst cycle type; dropping cyc aborts it.
//
// Build option: define BURST_SEQ_TIMEOUT_EN to abort XFER after TO_CYCLES
// consecutive beat-less cycles (err_o pulses). Undefined: err_o is tied 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   cyc_i, stb_i      per-requester Wishbone cycle / strobe (bit k = req k)
//   adr_i/cti_i/bte_i packed per-requester start address / cycle / burst type
//   ack_o             per-requester beat acknowledge
//   adr_o/cti_o/bte_o granted requester's fields to the address generator
//   init_o, inc_o     generator load strobe / per-beat advance strobe
//   done_i            generator last-beat flag (used in XFER)
//   mem_rdy_i         memory can complete a beat this cycle
//   gnt_o, busy_o     granted requester index / sequencer not idle
//   err_o             timeout pulse
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// INIT  | init_o pulse, generator loads the granted fields
// LOAD  | generator's delayed load settles, no acknowledge yet
// XFER  | beats acknowledged while mem_rdy_i and granted stb/cyc are high
module wb_burst_seq #(
  parameter logic [7:0] TO_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cyc_i,
  input  logic [3:0]  stb_i,
  input  logic [15:0] adr_i,
  input  logic [11:0] cti_i,
  input  logic [7:0]  bte_i,
  output logic [3:0]  ack_o,
  output logic [3:0]  adr_o,
  output logic [2:0]  cti_o,
  output logic [1:0]  bte_o,
  output logic        init_o,
  output logic        inc_o,
  input  logic        done_i,
  input  logic        mem_rdy_i,
  output logic [1:0]  gnt_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, INIT, LOAD, XFER} state_t;

  state_t     state, state_nx;
  logic [1:0] last_gnt;
  logic [1:0] winner;
  logic       any_req;
  logic       beat;
  logic       burst_end;
  logic       lg_upd;
  logic       timeout;
  logic [3:0] req;

  assign req = cyc_i & stb_i;

  // Round-robin: try last_gnt+1, +2, +3 and finally last_gnt itself.
  always_comb begin
    winner  = 2'd0;
    any_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!any_req && req[2'(last_gnt + 2'(i))]) begin
        winner  = 2'(last_gnt + 2'(i));
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    adr_o = adr_i[3:0];
    cti_o = cti_i[2:0];
    bte_o = bte_i[1:0];
    case (gnt_o)
      2'd1: begin adr_o = adr_i[7:4];   cti_o = cti_i[5:3];  bte_o = bte_i[3:2]; end
      2'd2: begin adr_o = adr_i[11:8];  cti_o = cti_i[8:6];  bte_o = bte_i[5:4]; end
      2'd3: begin adr_o = adr_i[15:12]; cti_o = cti_i[11:9]; bte_o = bte_i[7:6]; end
      default: ;
    endcase
  end

  assign beat      = (state == XFER) && mem_rdy_i && stb_i[gnt_o] && cyc_i[gnt_o];
  assign burst_end = done_i || (cti_o == 3'b111) || (cti_o == 3'b000);

`ifdef BURST_SEQ_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Beat-less XFER cycles; cleared outside XFER so it starts at 0 on entry.
  assign timeout = (state == XFER) && !beat && (to_cnt >= TO_CYCLES);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= 8'd0;
    else if ((state == XFER) && !beat && !timeout)
      to_cnt <= to_cnt + 8'd1;
    else
      to_cnt <= 8'd0;
  end
`else
  logic unused_to_cycles;
  assign unused_to_cycles = ^TO_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    lg_upd   = 1'b0;
    init_o   = 1'b0;
    case (state)
      IDLE: if (any_req) state_nx = INIT;
      INIT: begin
        init_o = 1'b1;
        if (!cyc_i[gnt_o]) begin state_nx = IDLE; lg_upd = 1'b1; end
        else                    state_nx = LOAD;
      end
      LOAD: begin
        if (!cyc_i[gnt_o]) begin state_nx = IDLE; lg_upd = 1'b1; end
        else                    state_nx = XFER;
      end
      XFER: begin
        if (!cyc_i[gnt_o] || (beat && burst_end) || timeout) begin
          state_nx = IDLE;
          lg_upd   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ack_o  = beat ? (4'b0001 << gnt_o) : 4'b0000;
  assign inc_o  = beat;
  assign busy_o = (state != IDLE);
  assign err_o  = timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt_o    <= 2'd0;
      last_gnt <= 2'd3;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && any_req) gnt_o <= winner;
      if (lg_upd) last_gnt <= gnt_o;
    end
  end

endmodule

// File: tb/tb_wb_burst_seq.sv
// Directed bench for wb_burst_seq: reset values, single-requester burst
// timing, round-robin order, wait states, abort on cyc drop, asynchronous
// reset mid-burst and the optional timeout (or its absence).
module tb_wb_burst_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cyc_i, stb_i;
  logic [15:0] adr_i;
  logic [11:0] cti_i;
  logic [7:0]  bte_i;
  logic [3:0]  ack_o;
  logic [3:0]  adr_o;
  logic [2:0]  cti_o;
  logic [1:0]  bte_o;
  logic        init_o, inc_o, done_i, mem_rdy_i;
  logic [1:0]  gnt_o;
  logic        busy_o, err_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_burst_seq #(.TO_CYCLES(8'd4)) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .adr_i(adr_i),
    .cti_i(cti_i), .bte_i(bte_i), .ack_o(ack_o), .adr_o(adr_o),
    .cti_o(cti_o), .bte_o(bte_o), .init_o(init_o), .inc_o(inc_o),
    .done_i(done_i), .mem_rdy_i(mem_rdy_i), .gnt_o(gnt_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; cyc_i = '0; stb_i = '0; done_i = 1'b0; mem_rdy_i = 1'b0;
    tick; tick;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values, muxed fields show requester 0
    adr_i = 16'h4321; cti_i = 12'b111_000_011_010; bte_i = 8'b11_10_01_00;
    rst = 1'b0; cyc_i = '0; stb_i = '0; done_i = 1'b0; mem_rdy_i = 1'b0;
    tick; tick;
    chk("rst_ack", ack_o, 0);  chk("rst_busy", busy_o, 0);
    chk("rst_init", init_o, 0); chk("rst_inc", inc_o, 0);
    chk("rst_err", err_o, 0);  chk("rst_gnt", gnt_o, 0);
    chk("rst_adr", adr_o, 4'h1); chk("rst_cti", cti_o, 3'b010);
    chk("rst_bte", bte_o, 2'b00);

    // req0 four-beat incrementing burst
    rst = 1'b1; cyc_i = 4'b0001; stb_i = 4'b0001; mem_rdy_i = 1'b1;
    #1 chk("b0_idle_busy", busy_o, 0);
    tick; #1 chk("b0_init", init_o, 1); chk("b0_init_ack", ack_o, 0); chk("b0_gnt", gnt_o, 0);
    tick; #1 chk("b0_load_init", init_o, 0); chk("b0_load_ack", ack_o, 0);
    for (int b = 0; b < 4; b++) begin
      tick; done_i = (b == 3);
      #1 chk($sformatf("b0_ack%0d", b), ack_o, 4'b0001);
      chk($sformatf("b0_inc%0d", b), inc_o, 1);
    end
    tick; cyc_i = '0; stb_i = '0; done_i = 1'b0;
    #1 chk("b0_end_busy", busy_o, 0); chk("b0_end_ack", ack_o, 0);

    // all four requesting single beats: 0,1,2,3,0
    do_reset;
    cti_i = '0; cyc_i = 4'b1111; stb_i = 4'b1111; mem_rdy_i = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick; #1 chk($sformatf("rr_gnt%0d", g), gnt_o, g % 4);
      tick; tick;
      #1 chk($sformatf("rr_ack%0d", g), ack_o, 4'b0001 << (g % 4));
      tick; #1 chk($sformatf("rr_idle%0d", g), busy_o, 0);
    end
    cyc_i = '0; stb_i = '0;

    // req2 with memory wait state
    do_reset;
    cti_i = 12'b010_010_010_010; adr_i = 16'h0A00;
    cyc_i = 4'b0100; stb_i = 4'b0100;
    tick; #1 chk("w_gnt", gnt_o, 2); chk("w_adr_init", adr_o, 4'hA);
    tick; tick; mem_rdy_i = 1'b1;
    #1 chk("w_ack1", ack_o, 4'b0100); chk("w_inc1", inc_o, 1); chk("w_adr1", adr_o, 4'hA);
    tick; mem_rdy_i = 1'b0;
    #1 chk("w_ack0", ack_o, 0); chk("w_inc0", inc_o, 0); chk("w_busy", busy_o, 1);
    tick; mem_rdy_i = 1'b1; done_i = 1'b1;
    #1 chk("w_ack2", ack_o, 4'b0100); chk("w_inc2", inc_o, 1); chk("w_adr2", adr_o, 4'hA);
    tick; cyc_i = '0; stb_i = '0; done_i = 1'b0;
    #1 chk("w_end_busy", busy_o, 0);

    // req1 drops cyc in LOAD; next search starts at 2
    do_reset;
    cyc_i = 4'b0010; stb_i = 4'b0010; mem_rdy_i = 1'b1;
    tick; #1 chk("ab_gnt", gnt_o, 1);
    tick; cyc_i = '0; stb_i = '0;
    #1 chk("ab_load_ack", ack_o, 0);
    tick; #1 chk("ab_idle", busy_o, 0); chk("ab_idle_ack", ack_o, 0);
    cyc_i = 4'b1111; stb_i = 4'b1111;
    tick; #1 chk("ab_next_gnt", gnt_o, 2);

    // asynchronous reset in XFER
    tick; tick;
    #1 chk("ar_ack_before", ack_o, 4'b0100);
    #2 rst = 1'b0;
    #1 chk("ar_ack", ack_o, 0); chk("ar_inc", inc_o, 0);
    chk("ar_busy", busy_o, 0); chk("ar_gnt", gnt_o, 0);
    tick; cyc_i = 4'b1000; stb_i = 4'b1000; rst = 1'b1;
    tick; #1 chk("ar_gnt3", gnt_o, 3);
    do_reset;
    cyc_i = 4'b1001; stb_i = 4'b1001;
    tick; #1 chk("ar_gnt0", gnt_o, 0);

    // stalled XFER: timeout pulse, or indefinite wait
    do_reset;
    cyc_i = 4'b0001; stb_i = 4'b0001; mem_rdy_i = 1'b0;
    tick; tick; tick;
`ifdef BURST_SEQ_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      #1 chk($sformatf("to_err0_c%0d", c), err_o, 0);
      tick;
    end
    #1 chk("to_err1", err_o, 1); chk("to_busy", busy_o, 1);
    cyc_i = '0; stb_i = '0;
    tick; #1 chk("to_idle", busy_o, 0); chk("to_err_clr", err_o, 0);
`else
    for (int c = 1; c <= 10; c++) begin
      #1 chk($sformatf("nto_err_c%0d", c), err_o, 0);
      tick;
    end
    #1 chk("nto_busy", busy_o, 1); chk("nto_ack", ack_o, 0);
    cyc_i = '0; stb_i = '0;
    tick; #1 chk("nto_idle", busy_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_burst_seq.md
WB_BURST_SEQ -- requirements
Module: wb_burst_seq

Interface
REQ-001 Parameter TO_CYCLES, default 8'd255: XFER-state idle-beat limit before abort (used only with BURST_SEQ_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 cyc_i  input  4  Wishbone cycle, one bit per requester 0..3.
REQ-005 stb_i  input  4  Wishbone strobe per requester.
REQ-006 adr_i  input  16  start word address, requester k in bits [4k+3:4k].
REQ-007 cti_i  input  12  cycle type, requester k in bits [3k+2:3k].
REQ-008 bte_i  input  8  burst type, requester k in bits [2k+1:2k].
REQ-009 ack_o  output  4  per-requester beat acknowledge.
REQ-010 adr_o, cti_o, bte_o  output  4/3/2  granted requester's fields, muxed to address generator.
REQ-011 init_o  output  1  one-cycle load strobe to address generator.
REQ-012 inc_o  output  1  advance strobe to address generator, one per beat.
REQ-013 done_i  input  1  generator last-beat flag, valid in XFER.
REQ-014 mem_rdy_i  input  1  memory can complete a beat this cycle.
REQ-015 gnt_o  output  2  index of granted requester; busy_o output 1 high outside IDLE; err_o output 1 timeout pulse.

Function
REQ-016 FSM states: IDLE, INIT, LOAD, XFER; encoding free, exactly one state active.
REQ-017 IDLE: request k = cyc_i[k] & stb_i[k]; if any, register winner into gnt_o and go INIT; else stay.
REQ-018 Arbitration round-robin: search starts at (last_gnt+1) mod 4; last_gnt resets to 3, so requester 0 wins first.
REQ-019 INIT: init_o=1 exactly this cycle; next LOAD.
REQ-020 LOAD: init_o=0, no ack; one cycle for the generator's delayed load; next XFER.
REQ-021 XFER: beat = mem_rdy_i & stb_i[gnt_o] & cyc_i[gnt_o]; ack_o[gnt_o]=beat, inc_o=beat, same cycle (combinational from registered state).
REQ-022 Burst ends on beat with done_i=1, or cti_i[gnt]==3'b111, or cti_i[gnt]==3'b000; next IDLE, last_gnt<=gnt_o.
REQ-023 cyc_i[gnt_o] low in INIT, LOAD or XFER: abort to IDLE next cycle, no ack, last_gnt updated.
REQ-024 Minimum latency: request seen in IDLE at edge n; INIT cycle n+1; LOAD n+2; first ack n+3.
REQ-025 ack_o bits other than gnt_o always 0; ack_o=0 outside XFER.
REQ-026 adr_o/cti_o/bte_o = fields of gnt_o in all states (stable from INIT to end of burst).
REQ-027 New requests arriving during a burst are not granted until IDLE; one IDLE cycle between bursts minimum.
REQ-028 stb_i[gnt] low with cyc high in XFER: wait state, no beat, stay XFER.

Reset
REQ-029 rst low: state=IDLE, gnt_o=0, last_gnt=3, timeout counter=0, immediately (asynchronous).
REQ-030 Outputs during/after reset: ack_o=0, init_o=0, inc_o=0, busy_o=0, err_o=0, adr_o/cti_o/bte_o = requester 0 fields.
REQ-031 Reset asserted mid-burst: burst discarded, no further ack; release synchronous to clk resumes in IDLE.

Configuration
REQ-032 BURST_SEQ_TIMEOUT_EN defined: 8-bit counter clears on entering XFER and on each beat, increments each XFER cycle without beat; reaching TO_CYCLES forces IDLE next cycle and err_o=1 for one cycle.
REQ-033 BURST_SEQ_TIMEOUT_EN undefined: no counter, err_o tied 0, XFER waits indefinitely.

Verification
REQ-034 Req0 only, bte=00 cti=010, mem_rdy=1, done_i at 4th beat -> init_o at n+1, acks n+3..n+6, IDLE at n+7, gnt_o=0.
REQ-035 cyc_i=4'b1111 held, single beats cti=000 -> grants 0,1,2,3,0 in order, one ack each.
REQ-036 Req2 bursting, mem_rdy toggles 1,0,1 -> inc_o and ack_o[2] only on mem_rdy=1 cycles, adr_o=adr_i[11:8] throughout.
REQ-037 cyc_i[1] dropped in LOAD -> IDLE next cycle, no ack_o[1], next grant searches from 2.
REQ-038 With BURST_SEQ_TIMEOUT_EN, TO_CYCLES=4, mem_rdy=0 in XFER -> err_o single pulse after 4 idle cycles, then IDLE; without macro err_o stays 0.
REQ-039 rst low mid-XFER -> ack_o, inc_o, busy_o 0 without clock edge; after release req3 wins only if req0..2 idle.
